// File: rtl/fetch_if.sv
// Bundle between the fetch stage and its surroundings: instruction-memory
// port, pipeline control from later stages, and the IF/ID register outputs.
//
// Control semantics: redirect_valid, flush and stall are level-sensitive
// commands sampled on every rising clock edge. Priority is
// redirect_valid > flush > stall > advance; imem_data must be valid in the
// same cycle that imem_addr is presented (combinational memory read).
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  // Fetch-stage side.
  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_inst,
    output if_id_pc,
    output if_id_pc4,
    output if_id_valid,
    output halted,
    output fault,
    output fetch_count
  );

  // Memory / pipeline-environment side.
  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  if_id_inst,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_valid,
    input  halted,
    input  fault,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, captures the returned word into the IF/ID register, and freezes
// on a halt instruction or an out-of-range fetch address. The halted output
// is the direct view of the RUN/HALT state register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // One past the last legal byte address; 34 bits so MEM_WORDS up to 2^30
  // cannot overflow the comparison.
  localparam logic [33:0] PC_LIMIT = 34'(MEM_WORDS) * 34'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic        pc_out_of_range;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
  assign pc_out_of_range  = ({2'b00, pc_q} >= PC_LIMIT);

  // State, PC and IF/ID register; asynchronous reset to the power-on values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: redirect > flush > stall > advance in both states.
  // A bubble clears valid and inst but leaves the PC fields untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;

    unique case (state_q)
      S_RUN: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_aligned;
          inst_d  = 32'h0;
          valid_d = 1'b0;
        end else if (bus.flush) begin
          inst_d  = 32'h0;
          valid_d = 1'b0;
          if (!bus.stall) begin
            pc_d = pc_plus4;
          end
        end else if (bus.stall) begin
          // Everything holds.
        end else if (pc_out_of_range) begin
          // Never present an out-of-range word downstream; freeze with fault.
          inst_d  = 32'h0;
          valid_d = 1'b0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          inst_d  = bus.imem_data;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          if (bus.imem_data == HALT_INST) begin
            // PC stays on the halt word so a debugger sees where fetch stopped.
            state_d = S_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      S_HALT: begin
        if (bus.redirect_valid) begin
          // The halt was on a wrong path; resume at the redirect target.
          pc_d    = redirect_aligned;
          inst_d  = 32'h0;
          valid_d = 1'b0;
          fault_d = 1'b0;
          state_d = S_RUN;
        end else if (bus.flush || !bus.stall) begin
          inst_d  = 32'h0;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc    = ipc_q;
  assign bus.if_id_pc4   = ipc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.fault       = fault_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a default-sized instance checked cycle by cycle
// against a behavioural model, plus a 4-word instance for the out-of-range
// fault path and asynchronous reset out of HALT.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs and memory ----------------
  fetch_if b1 ();
  fetch_if b2 ();

  logic [31:0] mem [0:255];

  assign b1.imem_data = mem[b1.imem_addr[9:2]];
  assign b2.imem_data = mem[b2.imem_addr[9:2]];

  // The small instance only ever free-runs.
  assign b2.stall          = 1'b0;
  assign b2.flush          = 1'b0;
  assign b2.redirect_valid = 1'b0;
  assign b2.redirect_pc    = 32'h0;

  fetch_stage #(.MEM_WORDS(65536)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
  fetch_stage #(.MEM_WORDS(4))     dut2 (.clk(clk), .rst(rst), .bus(b2.master));

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- behavioural reference model (dut1) ----------------
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_cnt;
  logic        m_valid, m_halt, m_fault;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_cnt = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
  endtask

  // Next visible state after one edge, derived from the fetch rules.
  task automatic model_step(input logic st, input logic fl, input logic rd,
                            input logic [31:0] rpc);
    logic [31:0] w;
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_inst = 32'h0;
      m_halt = 1'b0; m_fault = 1'b0;   // only meaningful when leaving HALT
    end else if (m_halt) begin
      if (fl || !st) begin m_valid = 1'b0; m_inst = 32'h0; end
    end else if (fl) begin
      m_valid = 1'b0; m_inst = 32'h0;
      if (!st) m_pc = m_pc + 4;
    end else if (!st) begin
      if (m_pc >= 32'd262144) begin
        m_valid = 1'b0; m_inst = 32'h0; m_halt = 1'b1; m_fault = 1'b1;
      end else begin
        w = mem[m_pc[9:2]];
        m_inst = w; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1'b1;
        m_cnt = m_cnt + 1;
        if (w == HALT) m_halt = 1'b1;
        else m_pc = m_pc + 4;
      end
    end
  endtask

  // PC fields of a bubble are not architecturally meaningful; mask them.
  function automatic logic [162:0] dut_vec();
    return {b1.imem_addr, b1.if_id_inst,
            b1.if_id_valid ? b1.if_id_pc  : 32'h0,
            b1.if_id_valid ? b1.if_id_pc4 : 32'h0,
            b1.if_id_valid, b1.halted, b1.fault, b1.fetch_count};
  endfunction

  function automatic logic [162:0] mdl_vec();
    return {m_pc, m_inst, m_valid ? m_ipc : 32'h0, m_valid ? m_ipc4 : 32'h0,
            m_valid, m_halt, m_fault, m_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    b1.stall = 1'b0; b1.flush = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = 32'h0;
  endtask

  // Apply inputs for one edge, advance the model, and return #1 after the edge.
  task automatic cycle(input logic st, input logic fl, input logic rd,
                       input logic [31:0] rpc);
    b1.stall = st; b1.flush = fl; b1.redirect_valid = rd; b1.redirect_pc = rpc;
    model_step(st, fl, rd, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_count();
    for (int i = 0; i < 256; i++) mem[i] = i + 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [162:0] obs, exp;
    drive_idle();
    rst = 1'b1;
    model_reset();
    #3;
    obs = dut_vec(); exp = mdl_vec(); n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset: got %h want %h", obs, exp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [162:0] obs, exp;
    fill_count();
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(i + 1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front();
      n_vec++;
      if (b1.if_id_inst !== e || b1.if_id_pc !== 32'(i * 4) || b1.if_id_valid !== 1'b1) begin
        n_err++;
        $display("FAIL free_run[%0d]: got inst %h pc %h v %b want inst %h pc %h v 1",
                 i, b1.if_id_inst, b1.if_id_pc, b1.if_id_valid, e, 32'(i * 4));
      end
      obs = dut_vec(); exp = mdl_vec(); n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL free_run_model[%0d]: got %h want %h", i, obs, exp);
      end
    end
    n_vec++;
    if (b1.fetch_count !== 32'd4) begin
      n_err++;
      $display("FAIL free_run_count: got %0d want 4", b1.fetch_count);
    end
  endtask

  task automatic test_stall();
    logic [162:0] obs, exp;
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (b1.imem_addr !== 32'h8 || b1.if_id_pc !== 32'h4 || b1.if_id_inst !== 32'd2 ||
          b1.fetch_count !== 32'd2) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got addr %h pc %h inst %h cnt %0d want 8 4 2 2",
                 i, b1.imem_addr, b1.if_id_pc, b1.if_id_inst, b1.fetch_count);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    obs = dut_vec(); exp = mdl_vec(); n_vec++;
    if (obs !== exp || b1.if_id_inst !== 32'd3 || b1.if_id_pc !== 32'h8) begin
      n_err++;
      $display("FAIL stall_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_redirect_combo();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h43);
    n_vec++;
    if (b1.imem_addr !== 32'h40 || b1.if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_combo: got addr %h v %b want 40 0", b1.imem_addr, b1.if_id_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (b1.if_id_pc !== 32'h40 || b1.if_id_pc4 !== 32'h44 || b1.if_id_inst !== 32'd17 ||
        b1.if_id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL redirect_target: got pc %h pc4 %h inst %h v %b want 40 44 11 1",
               b1.if_id_pc, b1.if_id_pc4, b1.if_id_inst, b1.if_id_valid);
    end
  endtask

  task automatic test_halt();
    logic [162:0] obs, exp;
    fill_count();
    mem[3] = HALT;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (b1.if_id_inst !== HALT || b1.if_id_pc !== 32'hC || b1.if_id_valid !== 1'b1 ||
        b1.halted !== 1'b1 || b1.imem_addr !== 32'hC || b1.fetch_count !== 32'd4) begin
      n_err++;
      $display("FAIL halt_capture: got inst %h pc %h v %b h %b addr %h cnt %0d",
               b1.if_id_inst, b1.if_id_pc, b1.if_id_valid, b1.halted, b1.imem_addr,
               b1.fetch_count);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (b1.if_id_valid !== 1'b0 || b1.halted !== 1'b1 || b1.imem_addr !== 32'hC ||
          b1.fault !== 1'b0) begin
        n_err++;
        $display("FAIL halt_bubble[%0d]: got v %b h %b addr %h f %b want 0 1 c 0",
                 i, b1.if_id_valid, b1.halted, b1.imem_addr, b1.fault);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 32'h20);
    obs = dut_vec(); exp = mdl_vec(); n_vec++;
    if (obs !== exp || b1.halted !== 1'b0 || b1.imem_addr !== 32'h20) begin
      n_err++;
      $display("FAIL halt_redirect: got %h want %h", obs, exp);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (b1.if_id_inst !== 32'd9 || b1.if_id_pc !== 32'h20 || b1.if_id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL halt_resume: got inst %h pc %h v %b want 9 20 1",
               b1.if_id_inst, b1.if_id_pc, b1.if_id_valid);
    end
    mem[3] = 32'd4;
  endtask

  task automatic test_random();
    logic [162:0] obs, exp;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic st, fl, rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = $urandom_range(0, 1023);
      cycle(st, fl, rd, rpc);
      obs = dut_vec(); exp = mdl_vec(); n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random[%0d] st%b fl%b rd%b: got %h want %h", c, st, fl, rd, obs, exp);
      end
    end
  endtask

  task automatic test_out_of_range();
    fill_count();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (b2.if_id_inst !== 32'(i + 1) || b2.if_id_pc !== 32'(i * 4) ||
          b2.if_id_valid !== 1'b1 || b2.halted !== 1'b0) begin
        n_err++;
        $display("FAIL oor_fetch[%0d]: got inst %h pc %h v %b h %b", i,
                 b2.if_id_inst, b2.if_id_pc, b2.if_id_valid, b2.halted);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (b2.if_id_valid !== 1'b0 || b2.halted !== 1'b1 || b2.fault !== 1'b1 ||
          b2.imem_addr !== 32'h10 || b2.fetch_count !== 32'd4) begin
        n_err++;
        $display("FAIL oor_halt[%0d]: got v %b h %b f %b addr %h cnt %0d want 0 1 1 10 4",
                 i, b2.if_id_valid, b2.halted, b2.fault, b2.imem_addr, b2.fetch_count);
      end
    end
  endtask

  task automatic test_reset_mid_halt();
    logic [162:0] obs, exp;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (b2.imem_addr !== 32'h0 || b2.if_id_inst !== 32'h0 || b2.if_id_pc !== 32'h0 ||
        b2.if_id_pc4 !== 32'h0 || b2.if_id_valid !== 1'b0 || b2.halted !== 1'b0 ||
        b2.fault !== 1'b0 || b2.fetch_count !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got addr %h inst %h pc %h pc4 %h v %b h %b f %b cnt %0d",
               b2.imem_addr, b2.if_id_inst, b2.if_id_pc, b2.if_id_pc4, b2.if_id_valid,
               b2.halted, b2.fault, b2.fetch_count);
    end
    obs = dut_vec(); exp = mdl_vec(); n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_reset_main: got %h want %h", obs, exp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    fill_count();
    @(posedge clk); #1;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_combo();
    test_halt();
    test_random();
    test_out_of_range();
    test_reset_mid_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
